// File: rtl/aes_mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns stage: one column per cycle through a
// single shared column unit, valid/ready on both sides, bypass for the final round.
module aes_mix_columns_seq #(
  parameter int unsigned NUM_COLS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic         inv,
  input  logic         bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  localparam logic [1:0] CNT_LAST = 2'(NUM_COLS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [127:0]  work_q, work_d;
  logic [127:0]  out_q, out_d;
  logic          inv_q, inv_d;

  logic          accept;
  logic [31:0]   col_sel;
  logic [31:0]   col_res;

  // GF(2^8) helpers; every constant multiply is a chain of xtime plus XOR.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv_mode);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m2 [4];
    logic [7:0] m3 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] o  [4];
    for (int unsigned r = 0; r < 4; r++) begin
      a[r]  = col[8*r +: 8];
      x2[r] = xtime(a[r]);
      x4[r] = xtime(x2[r]);
      x8[r] = xtime(x4[r]);
      m2[r] = x2[r];
      m3[r] = x2[r] ^ a[r];
      m9[r] = x8[r] ^ a[r];
      mb[r] = x8[r] ^ x2[r] ^ a[r];
      md[r] = x8[r] ^ x4[r] ^ a[r];
      me[r] = x8[r] ^ x4[r] ^ x2[r];
    end
    if (inv_mode) begin
      o[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      o[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      o[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      o[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end else begin
      o[0] = m2[0] ^ m3[1] ^ a[2]  ^ a[3];
      o[1] = a[0]  ^ m2[1] ^ m3[2] ^ a[3];
      o[2] = a[0]  ^ a[1]  ^ m2[2] ^ m3[3];
      o[3] = m3[0] ^ a[1]  ^ a[2]  ^ m2[3];
    end
    mix_col = {o[3], o[2], o[1], o[0]};
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = bypass ? OUT : CALC;
        end
      end
      CALC: begin
        if (cnt_q == CNT_LAST) begin
          state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          if (in_valid) begin
            state_d = bypass ? OUT : CALC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE:    in_ready = 1'b1;
      CALC:    in_ready = 1'b0;
      OUT: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign state_out = out_q;

  // Single shared column unit, fed by the column the counter points at.
  always_comb begin
    col_sel = work_q[31:0];
    unique case (cnt_q)
      2'd0: col_sel = work_q[31:0];
      2'd1: col_sel = work_q[63:32];
      2'd2: col_sel = work_q[95:64];
      2'd3: col_sel = work_q[127:96];
      default: col_sel = work_q[31:0];
    endcase
  end

  assign col_res = mix_col(col_sel, inv_q);

  // Datapath next-state; the result register is loaded only on entry to OUT.
  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    inv_d  = inv_q;
    out_d  = out_q;
    if (state_q == CALC) begin
      work_d[{cnt_q, 5'd0} +: 32] = col_res;
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        out_d = work_d;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end else if (accept) begin
      work_d = state_in;
      inv_d  = inv;
      cnt_d  = '0;
      if (bypass) begin
        out_d = state_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      work_q <= '0;
      out_q  <= '0;
      inv_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      work_q <= work_d;
      out_q  <= out_d;
      inv_q  <= inv_d;
    end
  end

endmodule

// File: tb/tb_aes_mix_columns_seq.sv
// Directed and streaming checks for aes_mix_columns_seq against hand-computed
// vectors and an independent shift-and-add GF(2^8) reference.
module tb_aes_mix_columns_seq;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         inv;
  logic         bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;

  int unsigned checks = 0;
  int unsigned errors = 0;

  aes_mix_columns_seq #(.NUM_COLS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .inv       (inv),
    .bypass    (bypass),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] din;
    logic         inv;
    logic         byp;
    int unsigned  lat;
    logic [127:0] dout;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_model(input logic [127:0] s, input logic iv, input logic bp);
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] r;
    if (bp) return s;
    if (iv) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = '0;
        for (int k = 0; k < 4; k++) begin
          acc = acc ^ gmul(coef[(k - row + 4) % 4], s[32*c + 8*k +: 8]);
        end
        r[32*c + 8*row +: 8] = acc;
      end
    end
    return r;
  endfunction

  // Present one state, wait (bounded) for accept, count edges to out_valid.
  task automatic run_txn(input string name, input vec_t v);
    int unsigned waited;
    int unsigned lat;
    @(negedge clk);
    in_valid = 1'b1;
    state_in = v.din;
    inv      = v.inv;
    bypass   = v.byp;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      chk({name, "_accept_timeout"}, 128'(in_ready), 128'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    inv      = ~v.inv;
    bypass   = ~v.byp;
    lat      = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "_latency"}, 128'(lat), 128'(v.lat));
    chk({name, "_data"}, state_out, v.dout);
  endtask

  task automatic drain;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  vec_t vecs [7];

  initial begin
    logic [127:0] held;
    logic         stable;
    logic         seen;
    logic [127:0] exp_q [$];
    logic [127:0] cur_in;
    logic         cur_inv, cur_byp;
    int unsigned  sent, recv, cyc;

    vecs[0] = '{128'hc6c6c6c6_01010101_5c220af2_455313db, 1'b0, 1'b0, 4,
                128'hc6c6c6c6_01010101_9d58dc9f_bca14d8e};
    vecs[1] = '{128'hc6c6c6c6_01010101_9d58dc9f_bca14d8e, 1'b1, 1'b0, 4,
                128'hc6c6c6c6_01010101_5c220af2_455313db};
    vecs[2] = '{128'h00112233_44556677_8899aabb_ccddeeff, 1'b0, 1'b1, 0,
                128'h00112233_44556677_8899aabb_ccddeeff};
    vecs[3] = '{128'h305dbfd4_305dbfd4_305dbfd4_305dbfd4, 1'b0, 1'b0, 4,
                128'he5816604_e5816604_e5816604_e5816604};
    vecs[4] = '{128'he5816604_e5816604_e5816604_e5816604, 1'b1, 1'b0, 4,
                128'h305dbfd4_305dbfd4_305dbfd4_305dbfd4};
    vecs[5] = '{128'hffeeddcc_bbaa9988_77665544_33221100, 1'b1, 1'b1, 0,
                128'hffeeddcc_bbaa9988_77665544_33221100};
    vecs[6] = '{128'h0, 1'b0, 1'b0, 4, 128'h0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    state_in = '0; inv = 1'b0; bypass = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 128'(out_valid), 128'd0);
    chk("reset_in_ready", 128'(in_ready), 128'd1);
    chk("reset_state_out", state_out, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i]);
      drain();
      chk($sformatf("vec%0d_released", i), 128'(out_valid), 128'd0);
    end

    // Backpressure, then same-cycle accept of the next state.
    run_txn("bp_first", vecs[0]);
    held   = state_out;
    stable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (!out_valid || state_out !== held || in_ready) stable = 1'b0;
    end
    chk("bp_hold_stable", 128'(stable), 128'd1);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    state_in  = vecs[3].din;
    inv       = 1'b0;
    bypass    = 1'b0;
    #1;
    chk("bp_in_ready_follows_out_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("bp_second_latency", 128'(cyc), 128'd4);
    chk("bp_second_data", state_out, vecs[3].dout);
    drain();

    // Reset in the middle of CALC discards the partial result.
    @(negedge clk);
    in_valid = 1'b1; state_in = vecs[0].din; inv = 1'b0; bypass = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_out_valid", 128'(out_valid), 128'd0);
    chk("midreset_in_ready", 128'(in_ready), 128'd1);
    chk("midreset_state_out", state_out, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("midreset_no_result", 128'(seen), 128'd0);

    // Streaming with random mode and random backpressure.
    sent = 0; recv = 0; cyc = 0;
    cur_in = {$urandom, $urandom, $urandom, $urandom};
    cur_inv = 1'($urandom); cur_byp = 1'($urandom);
    while (recv < 8 && cyc < 1000) begin
      @(negedge clk);
      in_valid  = (sent < 8);
      state_in  = cur_in;
      inv       = cur_inv;
      bypass    = cur_byp;
      out_ready = 1'($urandom);
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("stream_unexpected_output", state_out, 128'd0 ^ ~state_out);
        end else begin
          chk($sformatf("stream_out%0d", recv), state_out, exp_q.pop_front());
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(cur_in, cur_inv, cur_byp));
        sent++;
        cur_in  = {$urandom, $urandom, $urandom, $urandom};
        cur_inv = 1'($urandom);
        cur_byp = 1'($urandom);
      end
      cyc++;
    end
    chk("stream_count", 128'(recv), 128'd8);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("stream_no_duplicates", 128'(seen), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
